// File: rtl/bmc_sched_if.sv
// Bundle for bmc_sched: rx stream, shared branch-metric unit port, bm slot stream.
// slave = scheduler side, master = surrounding environment.
interface bmc_sched_if;
  logic       rx_valid;
  logic [1:0] rx_pair;
  logic       rx_ready;
  logic [1:0] bmc_rx_pair;
  logic [1:0] bmc_exp0;
  logic [1:0] bmc_exp1;
  logic [1:0] bmc_path_0;
  logic [1:0] bmc_path_1;
  logic       bm_valid;
  logic       bm_ready;
  logic [1:0] bm_state;
  logic [1:0] bm_p0;
  logic [1:0] bm_p1;
  logic       bm_last;
  logic       frame_done;

  modport slave (
    input  rx_valid,
    input  rx_pair,
    input  bmc_path_0,
    input  bmc_path_1,
    input  bm_ready,
    output rx_ready,
    output bmc_rx_pair,
    output bmc_exp0,
    output bmc_exp1,
    output bm_valid,
    output bm_state,
    output bm_p0,
    output bm_p1,
    output bm_last,
    output frame_done
  );

  modport master (
    output rx_valid,
    output rx_pair,
    output bmc_path_0,
    output bmc_path_1,
    output bm_ready,
    input  rx_ready,
    input  bmc_rx_pair,
    input  bmc_exp0,
    input  bmc_exp1,
    input  bm_valid,
    input  bm_state,
    input  bm_p0,
    input  bm_p1,
    input  bm_last,
    input  frame_done
  );
endinterface

// File: rtl/bmc_sched.sv
// Branch-metric scheduler: walks the 4 trellis states of each received pair
// through a shared metric unit and emits one registered metric slot per state.
module bmc_sched #(
  parameter int unsigned FRAME_LEN = 8
) (
  input logic        clk,
  input logic        rst,
  bmc_sched_if.slave bus
);

  localparam logic [7:0] LAST_SYM = 8'(FRAME_LEN - 1);

  typedef enum logic {
    IDLE,
    RUN
  } state_t;

  state_t     state;
  logic       rdy_q;
  logic [1:0] idx;
  logic [1:0] pair_q;
  logic [7:0] sym_cnt;
  logic       v_q;
  logic [1:0] st_q;
  logic [1:0] p0_q;
  logic [1:0] p1_q;
  logic       last_q;
  logic       done_q;

  logic       accept;
  logic       load;
  logic       consume;
  logic [1:0] exp0;

  assign accept  = bus.rx_valid && rdy_q;
  assign load    = (state == RUN) && (!v_q || bus.bm_ready);
  assign consume = v_q && bus.bm_ready && last_q;
  assign exp0    = {idx[1] ^ idx[0], idx[0]};

  assign bus.rx_ready    = rdy_q;
  assign bus.bmc_rx_pair = pair_q;
  assign bus.bmc_exp0    = exp0;
  assign bus.bmc_exp1    = ~exp0;
  assign bus.bm_valid    = v_q;
  assign bus.bm_state    = st_q;
  assign bus.bm_p0       = p0_q;
  assign bus.bm_p1       = p1_q;
  assign bus.bm_last     = last_q;
  assign bus.frame_done  = done_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      rdy_q   <= 1'b1;
      idx     <= 2'd0;
      pair_q  <= 2'd0;
      sym_cnt <= 8'd0;
      v_q     <= 1'b0;
      st_q    <= 2'd0;
      p0_q    <= 2'd0;
      p1_q    <= 2'd0;
      last_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;

      unique case (state)
        IDLE: begin
          if (accept) begin
            pair_q <= bus.rx_pair;
            idx    <= 2'd0;
            state  <= RUN;
            rdy_q  <= 1'b0;
          end
        end
        RUN: begin
          if (load && idx == 2'd3) begin
            state <= IDLE;
            rdy_q <= 1'b1;
          end else if (load) begin
            idx <= idx + 2'd1;
          end
        end
        default: begin
          state <= IDLE;
          rdy_q <= 1'b1;
        end
      endcase

      // Slot holds while stalled; metrics pass straight through
      if (load) begin
        v_q    <= 1'b1;
        st_q   <= idx;
        p0_q   <= bus.bmc_path_0;
        p1_q   <= bus.bmc_path_1;
        last_q <= (idx == 2'd3);
      end else if (v_q && bus.bm_ready) begin
        v_q <= 1'b0;
      end

      if (consume) begin
        if (sym_cnt == LAST_SYM) begin
          sym_cnt <= 8'd0;
          done_q  <= 1'b1;
        end else begin
          sym_cnt <= sym_cnt + 8'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_bmc_sched.sv
// Directed bench for bmc_sched with a Hamming-distance branch-metric unit.
// Inputs change and outputs are sampled 1 time unit after each rising edge.
module tb_bmc_sched;

  logic clk;
  logic rst;
  int   n_assert;
  int   n_fail;
  int   npulse;
  logic [1:0] nxt;

  bmc_sched_if bus ();

  bmc_sched #(
    .FRAME_LEN(8)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  function automatic logic [1:0] hd(input logic [1:0] a, input logic [1:0] b);
    logic [1:0] x;
    x = a ^ b;
    return {1'b0, x[1]} + {1'b0, x[0]};
  endfunction

  always_comb begin
    bus.bmc_path_0 = hd(bus.bmc_rx_pair, bus.bmc_exp0);
    bus.bmc_path_1 = hd(bus.bmc_rx_pair, bus.bmc_exp1);
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs,
                     input logic [7:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic slot(input string tag, input logic [1:0] st,
                      input logic [1:0] p0, input logic [1:0] p1,
                      input logic last);
    chk({tag, ".valid"}, 8'(bus.bm_valid), 8'd1);
    chk({tag, ".state"}, 8'(bus.bm_state), 8'(st));
    chk({tag, ".p0"}, 8'(bus.bm_p0), 8'(p0));
    chk({tag, ".p1"}, 8'(bus.bm_p1), 8'(p1));
    chk({tag, ".last"}, 8'(bus.bm_last), 8'(last));
  endtask

  initial begin
    n_assert = 0;
    n_fail = 0;
    npulse = 0;
    rst = 1'b0;
    bus.rx_valid = 1'b0;
    bus.rx_pair = 2'b00;
    bus.bm_ready = 1'b1;

    repeat (2) cyc();
    chk("rst.rx_ready", 8'(bus.rx_ready), 8'd1);
    chk("rst.bm_valid", 8'(bus.bm_valid), 8'd0);
    chk("rst.rx_pair", 8'(bus.bmc_rx_pair), 8'd0);
    chk("rst.p0", 8'(bus.bm_p0), 8'd0);
    chk("rst.p1", 8'(bus.bm_p1), 8'd0);
    chk("rst.state", 8'(bus.bm_state), 8'd0);
    chk("rst.last", 8'(bus.bm_last), 8'd0);
    chk("rst.done", 8'(bus.frame_done), 8'd0);
    rst = 1'b1;

    // pair 01, downstream always ready
    bus.rx_valid = 1'b1;
    bus.rx_pair = 2'b01;
    cyc();
    bus.rx_valid = 1'b0;
    chk("lat.rx_ready", 8'(bus.rx_ready), 8'd0);
    chk("lat.bm_valid", 8'(bus.bm_valid), 8'd0);
    chk("lat.pair", 8'(bus.bmc_rx_pair), 8'd1);
    cyc();
    slot("p01.s0", 2'd0, 2'd1, 2'd1, 1'b0);
    cyc();
    slot("p01.s1", 2'd1, 2'd1, 2'd1, 1'b0);
    cyc();
    slot("p01.s2", 2'd2, 2'd2, 2'd0, 1'b0);
    cyc();
    slot("p01.s3", 2'd3, 2'd0, 2'd2, 1'b1);
    chk("p01.rx_ready", 8'(bus.rx_ready), 8'd1);
    cyc();
    chk("p01.drain", 8'(bus.bm_valid), 8'd0);

    // pair 00
    bus.rx_valid = 1'b1;
    bus.rx_pair = 2'b00;
    cyc();
    bus.rx_valid = 1'b0;
    cyc();
    slot("p00.s0", 2'd0, 2'd0, 2'd2, 1'b0);
    repeat (3) cyc();
    slot("p00.s3", 2'd3, 2'd1, 2'd1, 1'b1);
    chk("p00.rx_ready", 8'(bus.rx_ready), 8'd1);

    // rx_valid held high: accept while state-3 slot pending
    bus.rx_valid = 1'b1;
    bus.rx_pair = 2'b10;
    for (int i = 0; i < 10; i++) begin
      chk("hold.rx_ready", 8'(bus.rx_ready), 8'((i % 5) == 0));
      chk("hold.bm_valid", 8'(bus.bm_valid), 8'((i % 5) != 1));
      if ((i % 5) != 1)
        chk("hold.state", 8'(bus.bm_state),
            ((i % 5) == 0) ? 8'd3 : 8'((i % 5) - 2));
      if (i >= 2)
        chk("hold.pair", 8'(bus.bmc_rx_pair), 8'd2);
      cyc();
    end

    // stall on state 1
    bus.rx_pair = 2'b01;
    cyc();
    bus.rx_valid = 1'b0;
    cyc();
    slot("stl.s0", 2'd0, 2'd1, 2'd1, 1'b0);
    cyc();
    slot("stl.s1", 2'd1, 2'd1, 2'd1, 1'b0);
    bus.bm_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      cyc();
      slot("stl.hold", 2'd1, 2'd1, 2'd1, 1'b0);
    end
    bus.bm_ready = 1'b1;
    cyc();
    slot("stl.s2", 2'd2, 2'd2, 2'd0, 1'b0);
    cyc();
    slot("stl.s3", 2'd3, 2'd0, 2'd2, 1'b1);
    chk("stl.done", 8'(bus.frame_done), 8'd0);

    // reset in RUN with idx=2
    bus.rx_valid = 1'b1;
    bus.rx_pair = 2'b11;
    cyc();
    bus.rx_valid = 1'b0;
    cyc();
    slot("p11.s0", 2'd0, 2'd2, 2'd0, 1'b0);
    cyc();
    chk("p11.s1", 8'(bus.bm_state), 8'd1);
    rst = 1'b0;
    #1;
    chk("mid.bm_valid", 8'(bus.bm_valid), 8'd0);
    chk("mid.rx_ready", 8'(bus.rx_ready), 8'd1);
    chk("mid.pair", 8'(bus.bmc_rx_pair), 8'd0);
    chk("mid.state", 8'(bus.bm_state), 8'd0);
    chk("mid.done", 8'(bus.frame_done), 8'd0);
    repeat (2) cyc();

    // 16 back-to-back symbols after reset; noise on rx_pair between accepts
    bus.rx_valid = 1'b1;
    bus.rx_pair = 2'b00;
    rst = 1'b1;
    cyc();
    for (int j = 0; j < 85; j++) begin
      chk("frm.done", 8'(bus.frame_done), 8'((j == 40) || (j == 80)));
      chk("frm.rx_ready", 8'(bus.rx_ready), 8'((j % 5) == 4));
      chk("frm.pair", 8'(bus.bmc_rx_pair), 8'((j / 5) & 3));
      if (bus.frame_done) npulse++;
      nxt = 2'((j + 1) / 5);
      bus.rx_pair = ((j % 5) == 4) ? nxt : ~nxt;
      cyc();
    end
    chk("frm.pulses", 8'(npulse), 8'd2);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/bmc_sched.md
BMC_SCHED -- requirements
Module: bmc_sched

Interface
REQ-001 Parameter FRAME_LEN, default 8: number of received symbol pairs per frame; legal range 2..255.
REQ-002 clk  input  1  the single clock; all state updates on its rising edge.
REQ-003 rst  input  1  reset, asynchronous and active-low.
REQ-004 rx_valid  input  1  upstream has a received pair.
REQ-005 rx_pair  input  2  received code-bit pair.
REQ-006 rx_ready  output  1  the block accepts rx_pair this cycle.
REQ-007 bmc_rx_pair  output  2  pair driven to the shared branch-metric unit.
REQ-008 bmc_exp0  output  2  expected codeword for input bit 0 from the current trellis state.
REQ-009 bmc_exp1  output  2  expected codeword for input bit 1 from the current trellis state.
REQ-010 bmc_path_0  input  2  metric returned by the shared unit for bmc_exp0, combinational, same cycle.
REQ-011 bmc_path_1  input  2  metric returned by the shared unit for bmc_exp1, combinational, same cycle.
REQ-012 bm_valid  output  1  output slot holds metrics.
REQ-013 bm_ready  input  1  downstream accepts the slot.
REQ-014 bm_state  output  2  trellis state index {s1,s0} of the slot.
REQ-015 bm_p0, bm_p1  output  2 each  registered metrics for input 0 and input 1.
REQ-016 bm_last  output  1  slot is state 3, the final state of the current symbol.
REQ-017 frame_done  output  1  one-cycle pulse at the end of a frame.

Function
REQ-018 The FSM SHALL have two states: IDLE and RUN.
REQ-019 In IDLE, rx_ready SHALL be 1; in RUN it SHALL be 0.
REQ-020 On rx_valid&&rx_ready, the block SHALL capture rx_pair into pair_q, set idx=0 and go to RUN.
REQ-021 bmc_rx_pair SHALL equal pair_q at all times.
REQ-022 Expected codewords for state idx={s1,s0}: bmc_exp0 SHALL be {s1^s0, s0}.
REQ-023 bmc_exp1 SHALL be the bitwise complement of bmc_exp0.
REQ-024 Slot load condition: RUN && (!bm_valid || bm_ready).
REQ-025 On a slot load, the block SHALL register bm_p0=bmc_path_0, bm_p1=bmc_path_1, bm_state=idx, bm_last=(idx==3) and bm_valid=1.
REQ-026 On a slot load with idx<3, idx SHALL increment; with idx==3, the FSM SHALL return to IDLE.
REQ-027 If no slot load occurs and bm_valid&&bm_ready, bm_valid SHALL clear.
REQ-028 While bm_valid&&!bm_ready, all bm_* outputs SHALL hold stable.
REQ-029 Latency: the first slot SHALL be valid 2 cycles after rx acceptance when downstream is ready.
REQ-030 Sustained throughput: one symbol per 5 cycles; one state per cycle while RUN and ready.
REQ-031 A new symbol SHALL be accepted in IDLE while the state-3 slot is still pending.
REQ-032 Metrics from the shared unit SHALL be passed through unmodified; the block performs no arithmetic on them.
REQ-033 sym_cnt, width 8, SHALL increment when a slot with bm_last=1 is consumed (bm_valid&&bm_ready&&bm_last).
REQ-034 When that consumption occurs with sym_cnt==FRAME_LEN-1, frame_done SHALL pulse for exactly 1 cycle and sym_cnt SHALL wrap to 0.
REQ-035 rx_valid with no acceptance SHALL leave all state unchanged.

Reset
REQ-036 Assertion of rst (low) SHALL asynchronously force IDLE, idx=0, pair_q=0 and sym_cnt=0.
REQ-037 Reset SHALL force bm_valid=0, bm_p0=0, bm_p1=0, bm_state=0, bm_last=0 and frame_done=0; outputs SHALL read rx_ready=1 and bmc_rx_pair=0.
REQ-038 Reset mid-RUN SHALL discard the in-flight symbol with no partial frame_done; the first accept after deassertion SHALL start a fresh frame.

Verification
REQ-039 Bench shared unit = Hamming distance; rx_pair=01, bm_ready=1 -> states 0..3 give (p0,p1)=(1,1),(1,1),(2,0),(0,2); bm_last only on state 3.
REQ-040 rx_pair=00 -> state 0 gives p0=0, p1=2; state 3 gives p0=1, p1=1; idle gap of 1 cycle before the next accept.
REQ-041 bm_ready held low 3 cycles on state 1 -> state-1 slot stable for those cycles, idx stalls, no slot lost or duplicated.
REQ-042 FRAME_LEN=8, 8 symbols back-to-back -> frame_done exactly once, in the cycle after the 8th state-3 consumption; 16 symbols -> 2 pulses.
REQ-043 rst low during RUN at idx=2 -> bm_valid=0 immediately; after release, 8 further symbols -> frame_done after the 8th.
REQ-044 rx_valid held high continuously -> rx_ready pattern 1,0,0,0,0 repeating; exactly one capture per symbol.
